// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: XLEN, NOP_INSTR bubble encoding, default reset PC,
// and the IF/ID pipeline register payload type.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- the canonical bubble
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: instruction memory port, hazard/redirect inputs, IF/ID outputs.
// Latency: n/a (wires only).
// Backpressure: stall holds the fetch side; redirect overrides stall.
//
// master: the fetch unit (drives imem_addr, if_id_*, fault and count).
// slave:  the environment (memory, hazard unit, branch resolution, ID stage).
interface instruction_fetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_data;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic            misalign_fault;
    logic [XLEN-1:0] fault_pc;
    logic [XLEN-1:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        output if_id_valid,
        output if_id_instr,
        output if_id_pc,
        output if_id_pc_plus4,
        output misalign_fault,
        output fault_pc,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output redirect_valid,
        output redirect_target,
        input  if_id_valid,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_pc_plus4,
        input  misalign_fault,
        input  fault_pc,
        input  fetch_count
    );

endinterface

// File: rtl/if_id_register.sv
// Pipeline register holding an if_id_t with load / hold / flush controls.
// Latency: 1 cycle from d to q on load.
// Backpressure: load=0 and flush=0 holds contents; flush beats load.
//
// Ports: clk, rst (sync, active-high), load, flush, d, q.
// Flush inserts a bubble but keeps pc/pc_plus4 so downstream debug still
// sees the last real PC.
module if_id_register
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] FLUSH_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q.valid    <= 1'b0;
            q.instr    <= FLUSH_INSTR;
            q.pc       <= '0;
            q.pc_plus4 <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= FLUSH_INSTR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, drives the combinational imem, fills IF/ID.
// Latency: 0 cycles PC->imem_addr, 1 cycle imem_data->IF/ID.
// Backpressure: stall freezes PC, IF/ID and count; redirect overrides stall and flushes.
//
// Ports: clk, rst (sync, active-high), bus (instruction_fetch_unit_if.master).
// Priority per edge: rst > redirect_valid > stall > advance.
module instruction_fetch_unit
    import riscv_pkg::XLEN;
    import riscv_pkg::if_id_t;
#(
    parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_q;
    logic [XLEN-1:0] fault_pc_q;
    logic [XLEN-1:0] fetch_count_q;
    logic            advance;
    logic            target_misaligned;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    assign pc_plus4          = pc_q + 32'd4;
    assign advance           = !bus.redirect_valid && !bus.stall;
    assign target_misaligned = bus.redirect_target[1:0] != 2'b00;

    assign if_id_d = '{valid: 1'b1, instr: bus.imem_data, pc: pc_q, pc_plus4: pc_plus4};

    if_id_register #(.FLUSH_INSTR(NOP_INSTR)) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (advance),
        .flush (bus.redirect_valid),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else if (bus.redirect_valid) begin
            // Low bits dropped so the PC stays word aligned; the fault flags it.
            pc_q <= {bus.redirect_target[XLEN-1:2], 2'b00};
            if (target_misaligned) begin
                misalign_q <= 1'b1;
                // Only the first offender is recorded.
                if (!misalign_q)
                    fault_pc_q <= bus.redirect_target;
            end
        end else if (!bus.stall) begin
            pc_q          <= pc_plus4;
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.imem_addr      = pc_q;
    assign bus.if_id_valid    = if_id_q.valid;
    assign bus.if_id_instr    = if_id_q.instr;
    assign bus.if_id_pc       = if_id_q.pc;
    assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
    assign bus.misalign_fault = misalign_q;
    assign bus.fault_pc       = fault_pc_q;
    assign bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios then random traffic.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: random stall / redirect / reset mixed into the stimulus.
module tb_instruction_fetch_unit;

    logic clk;
    logic rst;

    instruction_fetch_unit_if ifc ();

    instruction_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_0093;
        if (a == 32'h4) return 32'h0000_8133;
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h1E5B};
    endfunction

    assign ifc.imem_data = mem_fn(ifc.imem_addr);

    // Reference state: what the fetch stage must look like after each edge.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fpc, m_cnt;
    logic        m_valid, m_fault;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic st, input logic rv, input logic [31:0] tgt);
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13; m_ipc = 32'h0; m_ipc4 = 32'h0;
            m_fault = 1'b0; m_fpc = 32'h0; m_cnt = 32'h0;
        end else if (rv) begin
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_instr = 32'h13;
            if (tgt % 4 != 0) begin
                if (!m_fault) m_fpc = tgt;
                m_fault = 1'b1;
            end
        end else if (!st) begin
            m_instr = mem_fn(m_pc);
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    task automatic compare_all();
        chk("imem_addr",      ifc.imem_addr,              m_pc);
        chk("if_id_valid",    {31'b0, ifc.if_id_valid},   {31'b0, m_valid});
        chk("if_id_instr",    ifc.if_id_instr,            m_instr);
        chk("if_id_pc",       ifc.if_id_pc,               m_ipc);
        chk("if_id_pc_plus4", ifc.if_id_pc_plus4,         m_ipc4);
        chk("misalign_fault", {31'b0, ifc.misalign_fault}, {31'b0, m_fault});
        chk("fault_pc",       ifc.fault_pc,               m_fpc);
        chk("fetch_count",    ifc.fetch_count,            m_cnt);
    endtask

    // One clock: apply inputs, advance model at the edge, compare just after it.
    task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] tgt);
        rst                 = r;
        ifc.stall           = st;
        ifc.redirect_valid  = rv;
        ifc.redirect_target = tgt;
        @(posedge clk);
        model_edge(r, st, rv, tgt);
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1;
        ifc.stall = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_target = 32'h0;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h1234_5677);
        chk("rst_valid", {31'b0, ifc.if_id_valid}, 32'h0);
        chk("rst_instr", ifc.if_id_instr, 32'h0000_0013);
        chk("rst_addr",  ifc.imem_addr,   32'h0);
        chk("rst_count", ifc.fetch_count, 32'h0);

        // First fetches
        step(0, 0, 0, 0);
        chk("f1_instr", ifc.if_id_instr,    32'h0020_0093);
        chk("f1_pc",    ifc.if_id_pc,       32'h0);
        chk("f1_pc4",   ifc.if_id_pc_plus4, 32'h4);
        chk("f1_valid", {31'b0, ifc.if_id_valid}, 32'h1);
        chk("f1_addr",  ifc.imem_addr,      32'h4);
        step(0, 0, 0, 0);
        chk("f2_instr", ifc.if_id_instr, 32'h0000_8133);
        chk("f2_count", ifc.fetch_count, 32'h2);

        // Stall at pc 8 for three cycles
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("stall_addr",  ifc.imem_addr,   32'h8);
        chk("stall_instr", ifc.if_id_instr, 32'h0000_8133);
        chk("stall_count", ifc.fetch_count, 32'h2);
        step(0, 0, 0, 0);
        chk("post_stall_pc", ifc.if_id_pc, 32'h8);

        // Redirect with simultaneous stall
        step(0, 1, 1, 32'h24);
        chk("redir_addr",  ifc.imem_addr,   32'h24);
        chk("redir_valid", {31'b0, ifc.if_id_valid}, 32'h0);
        chk("redir_instr", ifc.if_id_instr, 32'h0000_0013);
        chk("redir_count", ifc.fetch_count, 32'h3);
        step(0, 0, 0, 0);
        chk("after_redir_pc", ifc.if_id_pc, 32'h24);

        // Misaligned targets: first one sticks
        step(0, 0, 1, 32'h4E);
        chk("mis_addr",  ifc.imem_addr, 32'h4C);
        chk("mis_flag",  {31'b0, ifc.misalign_fault}, 32'h1);
        chk("mis_fpc",   ifc.fault_pc,  32'h4E);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h41);
        chk("mis2_fpc",  ifc.fault_pc,  32'h4E);
        chk("mis2_addr", ifc.imem_addr, 32'h40);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_addr", ifc.imem_addr,      32'h0);
        chk("wrap_pc",   ifc.if_id_pc,       32'hFFFF_FFFC);
        chk("wrap_pc4",  ifc.if_id_pc_plus4, 32'h0);

        // Reset while stalled with a fault pending
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst2_flag",  {31'b0, ifc.misalign_fault}, 32'h0);
        chk("rst2_fpc",   ifc.fault_pc,  32'h0);
        chk("rst2_addr",  ifc.imem_addr, 32'h0);
        chk("rst2_instr", ifc.if_id_instr, 32'h0000_0013);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, st, rv;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < 30);
            rv  = ($urandom_range(0, 99) < 12);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
            step(r, st, rv, tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
